// File: rtl/add_mul_and_pkg.sv
// Shared defaults and operand types for the add-mul-and datapath and its stream shell.
package add_mul_and_pkg;

  localparam int WIDTH_DEFAULT   = 9;
  localparam int LATENCY_DEFAULT = 3;

  typedef logic [WIDTH_DEFAULT-1:0] operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
    operand_t c;
    operand_t d;
  } operand_beat_t;

endpackage

// File: rtl/sync_fifo_reg.sv
// Register-based, non-fall-through, in-order FIFO with occupancy count.
module sync_fifo_reg #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Upstream credit accounting must make this unreachable.
  push_while_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/add_mul_and_stream_shell.sv
// Valid/ready shell around a free-running fixed-latency datapath, with credit-based result buffering.
module add_mul_and_stream_shell
  import add_mul_and_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic [WIDTH-1:0] pipe_a,
  output logic [WIDTH-1:0] pipe_b,
  output logic [WIDTH-1:0] pipe_c,
  output logic [WIDTH-1:0] pipe_d,
  input  logic [WIDTH-1:0] pipe_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        credit_sum;
  logic               accept;
  logic               fifo_full, fifo_empty;

  assign pipe_a = in_a;
  assign pipe_b = in_b;
  assign pipe_c = in_c;
  assign pipe_d = in_d;

  // in_ready depends only on flopped state, so no in_valid/out_ready path exists.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
    credit_sum = {1'b0, fifo_count} + {1'b0, inflight};
    in_ready   = credit_sum < (CW + 1)'(DEPTH);
    accept     = in_valid && in_ready;
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  sync_fifo_reg #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_q[LATENCY-1]),
    .push_data (pipe_out),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (out_data)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (inflight != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_add_mul_and_stream_shell.sv
// Self-checking bench: behavioural datapath, scoreboard of expected results, directed vectors and corner sequences.
module tb_add_mul_and_stream_shell;
  import add_mul_and_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     in_valid, in_ready;
  operand_t in_a, in_b, in_c, in_d;
  operand_t pipe_a, pipe_b, pipe_c, pipe_d, pipe_out;
  logic     out_valid, out_ready;
  operand_t out_data;
  logic     busy;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;

  operand_t exp_q[$];
  logic     stall_prev = 1'b0;
  operand_t held_data;

  always #5 clk = ~clk;

  add_mul_and_stream_shell #(
    .WIDTH   (9),
    .LATENCY (3),
    .DEPTH   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .pipe_a    (pipe_a),
    .pipe_b    (pipe_b),
    .pipe_c    (pipe_c),
    .pipe_d    (pipe_d),
    .pipe_out  (pipe_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Free-running 3-stage datapath: sum, then product, then mask.
  operand_t s1_sum, s1_b, s1_c, s2_prod, s2_c, s3_out;
  always @(posedge clk) begin
    s1_sum  <= pipe_d + pipe_a;
    s1_b    <= pipe_b;
    s1_c    <= pipe_c;
    s2_prod <= s1_sum * s1_b;
    s2_c    <= s1_c;
    s3_out  <= s2_prod & s2_c;
  end
  assign pipe_out = s3_out;

  function automatic operand_t ref_result(input operand_beat_t bt);
    operand_t s, p;
    s = bt.d + bt.a;
    p = s * bt.b;
    return p & bt.c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input operand_beat_t bt);
    in_a = bt.a;
    in_b = bt.b;
    in_c = bt.c;
    in_d = bt.d;
  endtask

  function automatic operand_beat_t rand_beat();
    operand_beat_t bt;
    bt.a = 9'($urandom_range(0, 511));
    bt.b = 9'($urandom_range(0, 511));
    bt.c = 9'($urandom_range(0, 511));
    bt.d = 9'($urandom_range(0, 511));
    return bt;
  endfunction

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else if (rst === 1'b0) begin
      if (stall_prev && out_valid)
        check("out_data_stable", 32'(out_data), 32'(held_data));
      if (in_valid && in_ready)
        exp_q.push_back(ref_result('{a: in_a, b: in_b, c: in_c, d: in_d}));
      if (out_valid && out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("scoreboard_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
    end
  end

  task automatic run_single(input operand_beat_t bt, input operand_t exp, input string name);
    int lat;
    logic busy_ok;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    set_beat(bt);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid && lat < 10) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      lat++;
    end
    check({name, "_busy"}, 32'(busy_ok && busy), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'd3);
    check({name, "_data"}, 32'(out_data), 32'(exp));
    tick();
    check({name, "_drained"}, 32'({out_valid, busy}), 32'd0);
  endtask

  task automatic drain(input string name);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      tick();
      n++;
    end
    tick();
    check({name, "_drain_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_drain_idle"}, 32'({out_valid, busy}), 32'd0);
  endtask

  typedef struct packed {
    operand_beat_t beat;
    operand_t      exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, seen, acc, pops0;
    logic rdy_ok, quiet_ok;
    operand_beat_t bt;

    vecs[0] = '{beat: '{a: 9'd3,   b: 9'd5,   c: 9'h1FF, d: 9'd4},   exp: 9'd35};
    vecs[1] = '{beat: '{a: 9'd2,   b: 9'd7,   c: 9'h1FF, d: 9'h1FF}, exp: 9'd7};
    vecs[2] = '{beat: '{a: 9'd0,   b: 9'd32,  c: 9'h1FF, d: 9'd32},  exp: 9'd0};
    vecs[3] = '{beat: '{a: 9'd5,   b: 9'd3,   c: 9'h00F, d: 9'd10},  exp: 9'd13};
    vecs[4] = '{beat: '{a: 9'd100, b: 9'd9,   c: 9'h0F0, d: 9'd50},  exp: 9'd64};
    vecs[5] = '{beat: '{a: 9'd511, b: 9'd511, c: 9'h1FF, d: 9'd0},   exp: 9'd1};
    vecs[6] = '{beat: '{a: 9'd0,   b: 9'd0,   c: 9'h1FF, d: 9'd0},   exp: 9'd0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_single(vecs[i].beat, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Back-to-back throughput.
    out_ready = 1'b1;
    first = -1; last = -1; seen = 0; rdy_ok = 1'b1;
    for (int j = 0; j < 30; j++) begin
      if (j < 20) begin
        set_beat(rand_beat());
        in_valid = 1'b1;
        if (!in_ready) rdy_ok = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        if (first < 0) first = j;
        last = j;
        seen++;
      end
    end
    check("tput_in_ready", 32'(rdy_ok), 32'd1);
    check("tput_first", 32'(first), 32'd3);
    check("tput_last", 32'(last), 32'd22);
    check("tput_count", 32'(seen), 32'd20);
    drain("tput");

    // Backpressure fill.
    out_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 14; j++) begin
      set_beat(rand_beat());
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepts", 32'(acc), 32'd8);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    pops0 = n_pops;
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_return", 32'(in_ready), 32'd1);
    drain("bp");
    check("bp_pops", 32'(n_pops - pops0), 32'd8);

    // Reset with 2 buffered and 3 in flight.
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      set_beat(rand_beat());
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_state", 32'({out_valid, busy, in_ready}), 32'b001);
    out_ready = 1'b1;
    quiet_ok = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (out_valid || busy) quiet_ok = 1'b0;
    end
    check("rst_mid_quiet", 32'(quiet_ok), 32'd1);
    bt = '{a: 9'd1, b: 9'd1, c: 9'h1FF, d: 9'd1};
    run_single(bt, 9'd2, "post_rst");

    // Simultaneous push/pop with 7 buffered.
    out_ready = 1'b0;
    for (int j = 0; j < 7; j++) begin
      set_beat(rand_beat());
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    check("pp_seven_ready", 32'(in_ready), 32'd1);
    set_beat(rand_beat());
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pp_full_credit", 32'(in_ready), 32'd0);
    tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_count_held_ready", 32'(in_ready), 32'd1);
    set_beat(rand_beat());
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("pp_count_held_seven", 32'(in_ready), 32'd0);
    for (int j = 0; j < 5; j++) tick();
    drain("pp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
